lcd_spi_writer: RTL and testbench
=================================

LCD_SPI_WRITER -- requirements
Module: lcd_spi_writer

Interface
REQ-001 Parameter CLK_DIV, default 2, sys_clk cycles per SCL half-period; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 4, sys_clk cycles of enforced idle with lcd_cs high after each byte; legal range 1..255.
REQ-003 sys_clk  input  1  system clock; all logic on rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data  input  9  byte to send; bit 8 is D/C (0 = command, 1 = parameter/pixel data); bits 7:0 are the payload.
REQ-006 en_write  input  1  write request level; may be held high across many bytes.
REQ-007 wr_done  output  1  single-cycle pulse marking completion of one byte.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 lcd_cs  output  1  panel chip select, active-low.
REQ-010 lcd_dc  output  1  panel D/C line, equal to the latched data[8] for the byte in flight.
REQ-011 lcd_scl  output  1  SPI clock, mode 0 (idle low, panel samples on rising edge).
REQ-012 lcd_sda  output  1  SPI data, MSB first.

Function
REQ-013 FSM states: IDLE, SHIFT, GAP; all outputs are registered.
REQ-014 IDLE: when en_write=1 on a rising edge, latch data[7:0] into an 8-bit shift register, set lcd_dc<=data[8], lcd_cs<=0, lcd_sda<=data[7], lcd_scl<=0, bit counter<=0, divider<=0, and enter SHIFT.
REQ-015 IDLE with en_write=0: hold lcd_cs=1, lcd_scl=0; lcd_sda and lcd_dc keep their last values.
REQ-016 SHIFT: the divider counts 0..CLK_DIV-1; tick = (divider==CLK_DIV-1); the divider wraps to 0 on tick.
REQ-017 On each tick lcd_scl toggles; a 0->1 toggle changes nothing else.
REQ-018 On a 1->0 toggle with bit counter <7: increment the counter, shift the register left by one, and drive lcd_sda with the next bit, so data is stable a full half-period before the next rising edge.
REQ-019 On a 1->0 toggle with bit counter ==7: lcd_cs<=1, wr_done<=1 for exactly one cycle, load the gap counter, and enter GAP.
REQ-020 Byte latency: the wr_done pulse and the lcd_cs rise register on the 16*CLK_DIV-th sys_clk edge after the sampling edge (32 cycles at default).
REQ-021 GAP: count GAP_CYCLES sys_clk cycles with lcd_cs=1, then enter IDLE; en_write is not sampled in SHIFT or GAP.
REQ-022 With en_write held high, consecutive bytes are separated by exactly GAP_CYCLES+1 cycles of lcd_cs high, which gives the upstream formatter time to advance its data after wr_done.
REQ-023 Changes to data or deassertion of en_write during SHIFT/GAP are ignored; the latched byte completes unchanged.
REQ-024 Exactly 8 rising edges on lcd_scl per byte; lcd_scl is low whenever lcd_cs is high.

Reset
REQ-025 On sys_rst_n=0, immediately (asynchronously): state=IDLE, lcd_cs=1, lcd_scl=0, lcd_sda=0, lcd_dc=0, wr_done=0, busy=0, all counters and the shift register cleared.
REQ-026 Reset mid-byte aborts the transfer with no wr_done; after release the block waits in IDLE for a new en_write.

Structure
REQ-027 Shared package lcd_pkg holds the FSM state encoding and the ST7735 command constants CASET=9'h02A, RASET=9'h02B, RAMWR=9'h02C used by all LCD formatters.
REQ-028 One sub-module is natural: lcd_spi_tick, a CLK_DIV half-period tick generator with synchronous clear; all other logic stays in lcd_spi_writer.

Verification
REQ-029 CLK_DIV=2: data=9'h02A, single en_write pulse -> lcd_dc=0, lcd_sda sampled on lcd_scl rising edges = 0,0,1,0,1,0,1,0, 8 rising edges, wr_done one cycle at edge 32, lcd_cs high from the same edge.
REQ-030 data=9'h1FF -> lcd_dc=1, eight 1-bits; then data=9'h100 -> eight 0-bits; wr_done count = 2.
REQ-031 en_write held high for 11 bytes (CASET/RASET/RAMWR window sequence) -> 11 wr_done pulses, each gap of lcd_cs high = 5 cycles (GAP_CYCLES=4), no byte lost or duplicated.
REQ-032 data changed from 9'h0AA to 9'h055 and en_write dropped at cycle 10 of SHIFT -> transmitted bits still 1,0,1,0,1,0,1,0 and wr_done still pulses.
REQ-033 Assert sys_rst_n=0 after the 3rd rising edge of lcd_scl -> same cycle: lcd_cs=1, lcd_scl=0, busy=0; no wr_done; the next byte after release transmits correctly.
REQ-034 CLK_DIV=1 with data=9'h0C3 -> lcd_scl period of 2 cycles, bits 1,1,0,0,0,0,1,1, wr_done at edge 16.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_pkg : shared LCD definitions (writer FSM encoding, ST7735 cmds)  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } lcd_state_t;

  localparam logic [8:0] CASET = 9'h02A;
  localparam logic [8:0] RASET = 9'h02B;
  localparam logic [8:0] RAMWR = 9'h02C;

endpackage
`default_nettype wire

// File: rtl/lcd_spi_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_spi_tick : SCL half-period tick generator with synchronous clear |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lcd_spi_tick
  import lcd_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam logic [7:0] c_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_div;

  assign o_tick = (r_div == c_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_div <= 8'd0;
    end else if (i_clear || o_tick) begin
      r_div <= 8'd0;
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_spi_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lcd_spi_writer : 9-bit (D/C + byte) SPI mode-0 writer for LCD panels |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lcd_spi_writer
  import lcd_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_cs,
  output logic       lcd_dc,
  output logic       lcd_scl,
  output logic       lcd_sda
);

  localparam logic [7:0] c_GAP_LOAD = 8'(GAP_CYCLES - 1);

  lcd_state_t r_state, w_state_n;
  // Holds the bits still to be sent; the MSB goes straight to lcd_sda at latch time.
  logic [6:0] r_shift,   w_shift_n;
  logic [2:0] r_bit_cnt, w_bit_cnt_n;
  logic [7:0] r_gap_cnt, w_gap_cnt_n;
  logic       r_wr_done, w_wr_done_n;
  logic       r_cs,      w_cs_n;
  logic       r_dc,      w_dc_n;
  logic       r_scl,     w_scl_n;
  logic       r_sda,     w_sda_n;
  logic       w_tick;

  lcd_spi_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_clear   (r_state != ST_SHIFT),
    .o_tick    (w_tick)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= 7'd0;
      r_bit_cnt <= 3'd0;
      r_gap_cnt <= 8'd0;
      r_wr_done <= 1'b0;
      r_cs      <= 1'b1;
      r_dc      <= 1'b0;
      r_scl     <= 1'b0;
      r_sda     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_shift   <= w_shift_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_gap_cnt <= w_gap_cnt_n;
      r_wr_done <= w_wr_done_n;
      r_cs      <= w_cs_n;
      r_dc      <= w_dc_n;
      r_scl     <= w_scl_n;
      r_sda     <= w_sda_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_shift_n   = r_shift;
    w_bit_cnt_n = r_bit_cnt;
    w_gap_cnt_n = r_gap_cnt;
    w_wr_done_n = 1'b0;
    w_cs_n      = r_cs;
    w_dc_n      = r_dc;
    w_scl_n     = r_scl;
    w_sda_n     = r_sda;

    unique case (r_state)
      ST_IDLE: begin
        w_cs_n  = 1'b1;
        w_scl_n = 1'b0;
        if (en_write) begin
          w_shift_n   = data[6:0];
          w_dc_n      = data[8];
          w_sda_n     = data[7];
          w_cs_n      = 1'b0;
          w_bit_cnt_n = 3'd0;
          w_state_n   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          w_scl_n = ~r_scl;
          // Data only moves on the falling SCL edge so it is stable for the panel's rising-edge sample.
          if (r_scl) begin
            if (r_bit_cnt != 3'd7) begin
              w_bit_cnt_n = r_bit_cnt + 3'd1;
              w_sda_n     = r_shift[6];
              w_shift_n   = {r_shift[5:0], 1'b0};
            end else begin
              w_cs_n      = 1'b1;
              w_wr_done_n = 1'b1;
              w_gap_cnt_n = c_GAP_LOAD;
              w_state_n   = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == 8'd0) begin
          w_state_n = ST_IDLE;
        end else begin
          w_gap_cnt_n = r_gap_cnt - 8'd1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_cs_n    = 1'b1;
        w_scl_n   = 1'b0;
      end
    endcase
  end

  assign wr_done = r_wr_done;
  assign busy    = (r_state != ST_IDLE);
  assign lcd_cs  = r_cs;
  assign lcd_dc  = r_dc;
  assign lcd_scl = r_scl;
  assign lcd_sda = r_sda;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lcd_spi_writer : directed bench, CLK_DIV=2 and CLK_DIV=1 writers  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lcd_spi_writer;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [8:0] a_data = 9'd0, b_data = 9'd0;
  logic       a_en = 1'b0, b_en = 1'b0;
  logic       a_wr_done, a_busy, a_cs, a_dc, a_scl, a_sda;
  logic       b_wr_done, b_busy, b_cs, b_dc, b_scl, b_sda;

  int n_vec  = 0;
  int n_fail = 0;
  int wd_cnt_a = 0;

  always #5 sys_clk = ~sys_clk;

  lcd_spi_writer #(.CLK_DIV(2), .GAP_CYCLES(4)) u_dut_a (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .data (a_data), .en_write (a_en),
    .wr_done (a_wr_done), .busy (a_busy), .lcd_cs (a_cs), .lcd_dc (a_dc),
    .lcd_scl (a_scl), .lcd_sda (a_sda)
  );

  lcd_spi_writer #(.CLK_DIV(1), .GAP_CYCLES(4)) u_dut_b (
    .sys_clk (sys_clk), .sys_rst_n (sys_rst_n), .data (b_data), .en_write (b_en),
    .wr_done (b_wr_done), .busy (b_busy), .lcd_cs (b_cs), .lcd_dc (b_dc),
    .lcd_scl (b_scl), .lcd_sda (b_sda)
  );

  always @(negedge sys_clk) if (a_wr_done) wd_cnt_a++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [8:0] d, input logic en);
    if (sel) begin b_data = d; b_en = en; end
    else     begin a_data = d; a_en = en; end
  endtask

  // Sends one byte and observes it; drop_at=0 means a one-cycle en_write pulse.
  task automatic run_byte(input bit sel, input logic [8:0] d, input int drop_at, input logic [8:0] alt,
                          output logic [7:0] bits, output int nrise, output int lat,
                          output int period, output logic dc_done, output logic cs_done);
    logic prev, scl, sda, wd, bsy;
    int   first;
    bits = 8'd0; nrise = 0; lat = -1; period = -1; first = -1; prev = 1'b0;
    dc_done = 1'b0; cs_done = 1'b0;
    @(negedge sys_clk);
    drive(sel, d, 1'b1);
    @(posedge sys_clk); #1;
    if (drop_at == 0) drive(sel, d, 1'b0);
    for (int k = 1; k <= 300 && lat < 0; k++) begin
      @(posedge sys_clk); #1;
      if (k == drop_at) drive(sel, alt, 1'b0);
      scl = sel ? b_scl : a_scl;
      sda = sel ? b_sda : a_sda;
      wd  = sel ? b_wr_done : a_wr_done;
      if (scl && !prev) begin
        bits = {bits[6:0], sda};
        nrise++;
        if (nrise == 1) first = k;
        if (nrise == 2) period = k - first;
      end
      prev = scl;
      if (wd) begin
        lat = k;
        dc_done = sel ? b_dc : a_dc;
        cs_done = sel ? b_cs : a_cs;
      end
    end
    if (lat < 0) check("wr_done_timeout", 32'd0, 32'd1);
    @(posedge sys_clk); #1;
    wd = sel ? b_wr_done : a_wr_done;
    check("wr_done_one_cycle", {31'd0, wd}, 32'd0);
    for (int k = 0; k < 50; k++) begin
      bsy = sel ? b_busy : a_busy;
      if (!bsy) break;
      @(posedge sys_clk); #1;
    end
  endtask

  typedef struct {
    bit         sel;
    logic [8:0] d;
    int         drop_at;
    logic [8:0] alt;
    logic [7:0] exp_bits;
    logic       exp_dc;
    int         exp_lat;
    int         exp_period;
  } vec_t;

  vec_t tbl[5];
  logic [8:0] seq[11];

  initial begin
    logic [7:0] bits;
    int         nrise, lat, period, wd0, idx, run;
    logic       dc_done, cs_done, prev_cs, prev_scl;

    tbl[0] = '{1'b0, 9'h02A, 0,  9'h02A, 8'h2A, 1'b0, 32, 4};
    tbl[1] = '{1'b0, 9'h1FF, 0,  9'h1FF, 8'hFF, 1'b1, 32, 4};
    tbl[2] = '{1'b0, 9'h100, 0,  9'h100, 8'h00, 1'b1, 32, 4};
    tbl[3] = '{1'b0, 9'h0AA, 10, 9'h055, 8'hAA, 1'b0, 32, 4};
    tbl[4] = '{1'b1, 9'h0C3, 0,  9'h0C3, 8'hC3, 1'b0, 16, 2};

    seq = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h17F,
            9'h02B, 9'h100, 9'h100, 9'h100, 9'h19F, 9'h02C};

    // Reset values
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_cs",      {31'd0, a_cs},      32'd1);
    check("rst_scl",     {31'd0, a_scl},     32'd0);
    check("rst_sda",     {31'd0, a_sda},     32'd0);
    check("rst_dc",      {31'd0, a_dc},      32'd0);
    check("rst_wr_done", {31'd0, a_wr_done}, 32'd0);
    check("rst_busy",    {31'd0, a_busy},    32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      if (i == 1) wd0 = wd_cnt_a;
      run_byte(tbl[i].sel, tbl[i].d, tbl[i].drop_at, tbl[i].alt,
               bits, nrise, lat, period, dc_done, cs_done);
      check($sformatf("v%0d_bits", i),    {24'd0, bits},       {24'd0, tbl[i].exp_bits});
      check($sformatf("v%0d_rises", i),   nrise,               32'd8);
      check($sformatf("v%0d_latency", i), lat,                 tbl[i].exp_lat);
      check($sformatf("v%0d_period", i),  period,              tbl[i].exp_period);
      check($sformatf("v%0d_dc", i),      {31'd0, dc_done},    {31'd0, tbl[i].exp_dc});
      check($sformatf("v%0d_cs_at_done", i), {31'd0, cs_done}, 32'd1);
      if (i == 2) check("wr_done_count_ff_00", wd_cnt_a - wd0, 32'd2);
    end

    // Streaming with en_write held high
    wd0 = wd_cnt_a;
    idx = 0; run = 0; bits = 8'd0; prev_cs = 1'b1; prev_scl = 1'b0;
    @(negedge sys_clk);
    a_data = seq[0];
    a_en   = 1'b1;
    for (int k = 0; k < 800 && idx < 11; k++) begin
      @(posedge sys_clk); #1;
      if (a_cs && !prev_cs) run = 0;
      if (a_cs) run++;
      if (!a_cs && prev_cs) begin
        if (idx > 0) check($sformatf("stream_gap%0d", idx), run, 32'd5);
        bits = 8'd0;
      end
      if (a_scl && !prev_scl) bits = {bits[6:0], a_sda};
      if (a_wr_done) begin
        check($sformatf("stream_byte%0d", idx), {23'd0, a_dc, bits}, {23'd0, seq[idx]});
        idx++;
        if (idx < 11) a_data = seq[idx];
        else          a_en = 1'b0;
      end
      prev_cs  = a_cs;
      prev_scl = a_scl;
    end
    a_en = 1'b0;
    repeat (60) @(posedge sys_clk);
    #1;
    check("stream_bytes_seen", idx, 32'd11);
    check("stream_wr_done_count", wd_cnt_a - wd0, 32'd11);
    check("stream_idle_busy", {31'd0, a_busy}, 32'd0);

    // Reset after the third SCL rising edge
    @(negedge sys_clk);
    a_data = 9'h13C;
    a_en   = 1'b1;
    @(posedge sys_clk); #1;
    a_en = 1'b0;
    nrise = 0; prev_scl = 1'b0;
    for (int k = 0; k < 200 && nrise < 3; k++) begin
      @(posedge sys_clk); #1;
      if (a_scl && !prev_scl) nrise++;
      prev_scl = a_scl;
    end
    check("abort_third_rise", nrise, 32'd3);
    check("abort_busy_before", {31'd0, a_busy}, 32'd1);
    wd0 = wd_cnt_a;
    sys_rst_n = 1'b0;
    #1;
    check("abort_cs",   {31'd0, a_cs},   32'd1);
    check("abort_scl",  {31'd0, a_scl},  32'd0);
    check("abort_busy", {31'd0, a_busy}, 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    check("abort_no_wr_done", wd_cnt_a - wd0, 32'd0);
    check("abort_idle_cs", {31'd0, a_cs}, 32'd1);
    run_byte(1'b0, 9'h0C3, 0, 9'h0C3, bits, nrise, lat, period, dc_done, cs_done);
    check("after_abort_bits",    {24'd0, bits}, 32'h0000_00C3);
    check("after_abort_rises",   nrise,         32'd8);
    check("after_abort_latency", lat,           32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
